// File: rtl/rv32_pkg.sv
// Shared types for the data-external (dext) path of the rv32 hart:
// request record, Wishbone bridge FSM states and a request sanity helper.
package rv32_pkg;

   typedef struct packed {
      logic        wr;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] data;
   } dext_req_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS   = 2'd1,
      FAULT = 2'd2
   } wb_bridge_state_e;

   // A request may go on the bus only if word-aligned and at least one byte is selected.
   function automatic logic req_is_valid(input dext_req_t r);
      return (r.be != 4'b0000) && (r.addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/rv32_mod_dext_req_slot.sv
// One-entry holding register for a dext request that arrives while the bridge is busy.
// A push while full (and not popped in the same cycle) is dropped and flagged sticky.
module rv32_mod_dext_req_slot
   import rv32_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  logic      pop,
   input  dext_req_t din,
   output dext_req_t dout,
   output logic      full,
   output logic      overrun
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full    <= 1'b0;
         dout    <= '0;
         overrun <= 1'b0;
      end else begin
         if (pop)
            full <= 1'b0;
         // A pop frees the entry in the same cycle, so a simultaneous push is accepted.
         if (push && (!full || pop)) begin
            full <= 1'b1;
            dout <= din;
         end
         if (push && full && !pop)
            overrun <= 1'b1;
      end
   end

endmodule

// File: rtl/rv32_mod_dext_wb_bridge.sv
// Runs single-cycle dext requests as Wishbone B4 classic cycles with a one-deep
// pending slot, alignment fault path and a saturating bus timeout.
module rv32_mod_dext_wb_bridge
   import rv32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dext_req,
   input  logic        dext_wr,
   input  logic [3:0]  dext_be,
   input  logic [31:0] dext_addr,
   input  logic [31:0] dext_do,
   output logic [31:0] dext_di,
   output logic        dext_ack,
   output logic        dext_err,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_we,
   output logic [3:0]  wb_sel,
   output logic [31:0] wb_adr,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack,
   input  logic        wb_err,
   output logic        overrun
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES) : {CW{1'b1}};

   wb_bridge_state_e state, state_next;
   dext_req_t        new_req, slot_req, launch_req;
   logic             slot_full, slot_push, slot_pop;
   logic             launch, launch_ok, timeout, resp_ack, resp_err;
   logic [CW-1:0]    cnt;

   assign new_req = '{wr: dext_wr, be: dext_be, addr: dext_addr, data: dext_do};

   rv32_mod_dext_req_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .push    (slot_push),
      .pop     (slot_pop),
      .din     (new_req),
      .dout    (slot_req),
      .full    (slot_full),
      .overrun (overrun)
   );

   always_comb begin
      state_next = state;
      launch     = 1'b0;
      launch_req = new_req;
      slot_pop   = 1'b0;
      slot_push  = dext_req;
      resp_ack   = 1'b0;
      resp_err   = 1'b0;
      timeout    = (TIMEOUT_CYCLES != 0) && (cnt == CNT_MAX);
      case (state)
         IDLE: begin
            // The older pending request always goes first; a new one then waits in the slot.
            if (slot_full) begin
               launch     = 1'b1;
               slot_pop   = 1'b1;
               launch_req = slot_req;
            end else if (dext_req) begin
               launch    = 1'b1;
               slot_push = 1'b0;
            end
            if (launch)
               state_next = req_is_valid(launch_req) ? BUS : FAULT;
         end
         BUS: begin
            if (wb_err)
               resp_err = 1'b1;
            else if (wb_ack)
               resp_ack = 1'b1;
            else if (timeout)
               resp_err = 1'b1;
            if (resp_ack || resp_err)
               state_next = IDLE;
         end
         FAULT: begin
            resp_err   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign launch_ok = launch && req_is_valid(launch_req);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Decoded from the state register, so reset drops the bus cycle immediately.
   assign wb_cyc = (state == BUS);
   assign wb_stb = wb_cyc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_we    <= 1'b0;
         wb_sel   <= 4'b0;
         wb_adr   <= 32'b0;
         wb_dat_o <= 32'b0;
      end else if (launch_ok) begin
         wb_we    <= launch_req.wr;
         wb_sel   <= launch_req.be;
         wb_adr   <= launch_req.addr;
         wb_dat_o <= launch_req.data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dext_ack <= 1'b0;
         dext_err <= 1'b0;
         dext_di  <= 32'b0;
      end else begin
         dext_ack <= resp_ack;
         dext_err <= resp_err;
         dext_di  <= (resp_ack && !wb_we) ? wb_dat_i : 32'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (launch)
         cnt <= '0;
      else if ((state == BUS) && !resp_ack && !resp_err && (cnt != CNT_MAX))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: doc/rv32_mod_dext_wb_bridge.md
# rv32_mod_dext_wb_bridge

Downstream neighbour of the load/store unit. Takes the single-cycle `dext_*` data-request pulses and runs each one as a Wishbone B4 classic cycle. It returns a one-cycle `dext_ack`/`dext_err` pulse, with read data valid in the same cycle. A one-deep pending slot absorbs a request that arrives while a bus cycle is in flight. A bus timeout and an alignment check guarantee that the hart never stalls forever.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles in BUS before a forced error; 0 disables the timeout.

Ports:
- `clk`  in  1: clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `dext_req`  in  1: request pulse; request fields below are sampled when it is high.
- `dext_wr`  in  1: 1 = store, 0 = load.
- `dext_be`  in  4: byte enables.
- `dext_addr`  in  32: word address; bits [1:0] are expected to be 0.
- `dext_do`  in  32: store data.
- `dext_di`  out  32: load data; valid only while `dext_ack` is high, 0 otherwise.
- `dext_ack`  out  1: one-cycle success pulse.
- `dext_err`  out  1: one-cycle failure pulse.
- `wb_cyc`, `wb_stb`  out  1: bus cycle and strobe; always equal.
- `wb_we`  out  1: write enable.
- `wb_sel`  out  4: byte selects.
- `wb_adr`  out  32: bus address.
- `wb_dat_o`  out  32: bus write data.
- `wb_dat_i`  in  32: bus read data.
- `wb_ack`, `wb_err`  in  1: slave termination.
- `overrun`  out  1: sticky; set when a request is dropped; cleared only by reset.

## Operation
- FSM states:
  - IDLE: no bus cycle.
  - BUS: `wb_cyc`/`wb_stb` high, waiting for termination.
  - FAULT: one cycle that emits an alignment error.
- Request capture:
  - `dext_req` in IDLE with the pending slot empty launches directly.
  - Otherwise the request is written into the pending slot.
  - If the slot is already full, the request is dropped and `overrun` is set.
- Launch from IDLE, taking the pending slot first, else the new `dext_req`:
  - Valid request: go to BUS and register `wb_adr`/`wb_sel`/`wb_we`/`wb_dat_o` from the request.
  - Invalid request (`addr[1:0]` ≠ 0 or `be` == 0): go to FAULT. No bus cycle is issued.
- FAULT: `dext_err` pulses; next state IDLE.
- BUS termination priority: `wb_err` > `wb_ack` > timeout.
  - `wb_err`: `dext_err` next cycle.
  - `wb_ack`: `dext_ack` next cycle. For a load, `dext_di` is registered from `wb_dat_i`.
  - Timeout: counter reaches `TIMEOUT_CYCLES`; `dext_err` next cycle.
  - In every case the next state is IDLE and `wb_cyc`/`wb_stb` drop.
- Timeout counter:
  - Width `$clog2(TIMEOUT_CYCLES+1)`.
  - Cleared on entry to BUS; increments each BUS cycle without termination.
  - Saturates; it never wraps.
- `dext_di` is 0 for stores, for errors and whenever `dext_ack` is low.
- `dext_ack` and `dext_err` are never high in the same cycle.
- Reset values: every output is 0, including `overrun`. FSM goes to IDLE, the pending slot is emptied, the counter is cleared.
- Reset mid-BUS drops `wb_cyc` immediately (asynchronous reset). No response pulse is emitted for the aborted request.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Minimum load/store latency, with a zero-wait-state slave acking combinationally:
  - `dext_req` sampled at edge 0.
  - `wb_cyc` high in cycle 1; `wb_ack` sampled at edge 1.
  - `dext_ack` high in cycle 2.
- A pending request launches in the same cycle the response pulse is issued. This gives exactly one IDLE cycle with `wb_cyc` low between back-to-back bus cycles.
- Alignment fault: `dext_req` at edge 0, FAULT in cycle 1, `dext_err` high in cycle 2.
- Timeout with `TIMEOUT_CYCLES`=N: `dext_err` is high in cycle N+2 after a request sampled at edge 0.
- `dext_req` coinciding with termination in BUS: the request goes to the pending slot and launches on the following edge.

## Structure
- Shared package `rv32_pkg` holds:
  - `dext_req_t` struct: `wr`, `be[3:0]`, `addr[31:0]`, `data[31:0]`.
  - `wb_bridge_state_e` enum: IDLE, BUS, FAULT.
- The pending slot is a natural sub-module: `rv32_mod_dext_req_slot`. It is a one-entry register of `dext_req_t` with push/pop/full and overrun detect.
- The FSM, timeout counter and response registers stay in the top module.

## Test plan
- Load, 0-wait: `dext_addr`=0x100, `be`=0xF, slave acks in cycle 1 with 0xDEADBEEF -> `dext_ack` and `dext_di`=0xDEADBEEF in cycle 2; `dext_di`=0 in cycle 3.
- Store, 3 wait states: `addr`=0x204, `be`=0x3, `do`=0x1234 -> `wb_we`=1, `wb_sel`=0x3, `wb_dat_o`=0x1234 held until ack; `dext_ack` one cycle after ack; `dext_di`=0.
- Back-to-back: second `dext_req` during BUS -> it is pending; exactly one cycle with `wb_cyc` low; second bus cycle shows the second address. A third request while the slot is full -> `overrun`=1 and only two responses appear.
- Errors: `wb_err` and `wb_ack` high together -> `dext_err` only. `addr`=0x102 -> no `wb_cyc`, `dext_err` in cycle 2. `be`=0 -> same as the misaligned case.
- Timeout with `TIMEOUT_CYCLES`=4 and a slave that never responds -> `dext_err` in cycle 6, `wb_cyc` low afterwards. With `TIMEOUT_CYCLES`=0 and the same slave -> the bridge waits indefinitely.
- Reset asserted mid-BUS -> all outputs 0 asynchronously; after release, a new request completes normally and `overrun`=0.
